// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified instruction/data memory port arbiter.
package mem_arb_pkg;

  localparam int ADDR_W_DEF   = 8;
  localparam int STARVE_CNT_W = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } owner_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and RAM-side signals around the memory port arbiter.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = mem_arb_pkg::ADDR_W_DEF
);

  // Handshake: a requester raises *_req with stable address/data and holds both
  // until *_gnt is seen high in the same cycle; *_rvalid pulses exactly one
  // cycle after a read grant and carries *_rdata. Writes produce no response.
  logic              if_req;
  logic [31:0]       if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [31:0]       if_rdata;
  logic              dm_req;
  logic [31:0]       dm_addr;
  logic [3:0]        dm_wen;
  logic [31:0]       dm_wdata;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [31:0]       dm_rdata;
  logic              cancel;
  logic              ram_en;
  logic [3:0]        ram_wen;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  modport slave (
    input  if_req, if_addr, dm_req, dm_addr, dm_wen, dm_wdata, cancel, ram_rdata,
    output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
    output ram_en, ram_wen, ram_addr, ram_wdata
  );

  modport master (
    output if_req, if_addr, dm_req, dm_addr, dm_wen, dm_wdata, cancel, ram_rdata,
    input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
    input  ram_en, ram_wen, ram_addr, ram_wdata
  );

endinterface

// File: rtl/mem_arb_starve.sv
// Fetch starvation counter: counts consecutive lost arbitration cycles and
// raises force_if once the limit is reached.
module mem_arb_starve
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    if_req,
  input  logic                    if_gnt,
  output logic                    force_if,
  output logic [STARVE_CNT_W-1:0] starve_cnt
);

  assign force_if = (starve_cnt >= STARVE_CNT_W'(STARVE_MAX));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (if_gnt || !if_req) begin
      starve_cnt <= '0;
    end else if (starve_cnt != '1) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data-stage requests onto one synchronous-read RAM port.
// Optional perf counters are built when MEM_ARB_PERF_EN is defined.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int STARVE_MAX = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  mem_port_arbiter_if.slave       bus,
  output owner_t                  owner_dbg,
  output logic [STARVE_CNT_W-1:0] starve_cnt_dbg
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]             perf_conflict,
  output logic [31:0]             perf_if_stall
`endif
);

  logic        force_if;
  logic        if_gnt;
  logic        dm_gnt;
  logic        kill;
  logic        if_rvalid;
  logic        dm_rvalid;
  logic [31:0] if_hold;
  logic [31:0] dm_hold;
  owner_t      owner;

  mem_arb_starve #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .clk        (clk),
    .reset      (reset),
    .if_req     (bus.if_req),
    .if_gnt     (if_gnt),
    .force_if   (force_if),
    .starve_cnt (starve_cnt_dbg)
  );

  assign dm_gnt = bus.dm_req & ~force_if;
  assign if_gnt = bus.if_req & (~bus.dm_req | force_if);

  assign bus.if_gnt    = if_gnt;
  assign bus.dm_gnt    = dm_gnt;
  assign bus.ram_en    = if_gnt | dm_gnt;
  assign bus.ram_addr  = dm_gnt ? bus.dm_addr[ADDR_W+1:2] : bus.if_addr[ADDR_W+1:2];
  assign bus.ram_wen   = dm_gnt ? bus.dm_wen : 4'b0000;
  assign bus.ram_wdata = bus.dm_wdata;

  // A flush kills a fetch response either one cycle after a flushed grant or in the response cycle itself.
  assign if_rvalid = (owner == OWN_IF) & ~kill & ~bus.cancel;
  assign dm_rvalid = (owner == OWN_DM);

  assign bus.if_rvalid = if_rvalid;
  assign bus.dm_rvalid = dm_rvalid;
  assign bus.if_rdata  = if_rvalid ? bus.ram_rdata : if_hold;
  assign bus.dm_rdata  = dm_rvalid ? bus.ram_rdata : dm_hold;
  assign owner_dbg     = owner;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner   <= OWN_NONE;
      kill    <= 1'b0;
      if_hold <= '0;
      dm_hold <= '0;
    end else begin
      if (if_gnt)                              owner <= OWN_IF;
      else if (dm_gnt && bus.dm_wen == 4'b0000) owner <= OWN_DM;
      else                                     owner <= OWN_NONE;
      kill <= if_gnt & bus.cancel;
      if (if_rvalid) if_hold <= bus.ram_rdata;
      if (dm_rvalid) dm_hold <= bus.ram_rdata;
    end
  end

`ifdef MEM_ARB_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_conflict <= '0;
      perf_if_stall <= '0;
    end else begin
      if (bus.if_req && bus.dm_req && perf_conflict != '1)
        perf_conflict <= perf_conflict + 1'b1;
      if (bus.if_req && !if_gnt && perf_if_stall != '1)
        perf_if_stall <= perf_if_stall + 1'b1;
    end
  end
`endif

  // Address bits outside the RAM word index are intentionally ignored (aliasing).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.if_addr[31:ADDR_W+2], bus.if_addr[1:0],
                              bus.dm_addr[31:ADDR_W+2], bus.dm_addr[1:0]};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural byte-write RAM.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic       clk;
  logic       reset;
  owner_t     owner_dbg;
  logic [3:0] starve_cnt_dbg;
  int         n_assert;
  int         n_fail;
`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_conflict;
  logic [31:0] perf_if_stall;
`endif

  mem_port_arbiter_if #(.ADDR_W(8)) bus ();

  mem_port_arbiter #(.ADDR_W(8), .STARVE_MAX(3)) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus.slave),
    .owner_dbg      (owner_dbg),
    .starve_cnt_dbg (starve_cnt_dbg)
`ifdef MEM_ARB_PERF_EN
    ,
    .perf_conflict  (perf_conflict),
    .perf_if_stall  (perf_if_stall)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: synchronous read, byte writes, preloaded while reset is high.
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[4]  <= 32'h2402_0001;
      mem[5]  <= 32'h1111_2222;
      mem[8]  <= 32'hDEAD_BEEF;
      mem[16] <= 32'hAAAA_BBBB;
    end else if (bus.ram_en) begin
      for (int b = 0; b < 4; b++)
        if (bus.ram_wen[b]) mem[bus.ram_addr][b*8 +: 8] <= bus.ram_wdata[b*8 +: 8];
      if (bus.ram_wen == 4'b0000) bus.ram_rdata <= mem[bus.ram_addr];
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.if_req   = 1'b0;
    bus.if_addr  = 32'h0;
    bus.dm_req   = 1'b0;
    bus.dm_addr  = 32'h0;
    bus.dm_wen   = 4'h0;
    bus.dm_wdata = 32'h0;
    bus.cancel   = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [31:0] exp_dm;
  logic [31:0] exp_cnt;

  initial begin
    n_assert = 0;
    n_fail   = 0;
    bus.ram_rdata = 32'h0;
    idle();
    reset = 1'b1;
    #3;
    chk("rst_if_rvalid", 32'(bus.if_rvalid), 32'd0);
    chk("rst_dm_rvalid", 32'(bus.dm_rvalid), 32'd0);
    chk("rst_if_rdata", bus.if_rdata, 32'h0);
    chk("rst_dm_rdata", bus.dm_rdata, 32'h0);
    chk("rst_ram_en", 32'(bus.ram_en), 32'd0);
    chk("rst_owner", 32'(owner_dbg), 32'(OWN_NONE));
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    tick();

    // fetch only, back-to-back
    bus.if_req = 1'b1; bus.if_addr = 32'h0000_0010;
    mid();
    chk("f0_if_gnt", 32'(bus.if_gnt), 32'd1);
    chk("f0_dm_gnt", 32'(bus.dm_gnt), 32'd0);
    chk("f0_ram_en", 32'(bus.ram_en), 32'd1);
    chk("f0_ram_addr", 32'(bus.ram_addr), 32'd4);
    chk("f0_if_rvalid", 32'(bus.if_rvalid), 32'd0);
    tick();
    mid();
    chk("f1_if_gnt", 32'(bus.if_gnt), 32'd1);
    chk("f1_if_rvalid", 32'(bus.if_rvalid), 32'd1);
    chk("f1_if_rdata", bus.if_rdata, 32'h2402_0001);
    tick();
    bus.if_addr = 32'h0000_0413;
    mid();
    chk("f2_alias_addr", 32'(bus.ram_addr), 32'd4);
    chk("f2_if_rvalid", 32'(bus.if_rvalid), 32'd1);
    tick();
    bus.if_req = 1'b0;
    mid();
    chk("f3_if_gnt", 32'(bus.if_gnt), 32'd0);
    chk("f3_ram_en", 32'(bus.ram_en), 32'd0);
    chk("f3_if_rdata", bus.if_rdata, 32'h2402_0001);
    tick();
    mid();
    chk("f4_if_rvalid", 32'(bus.if_rvalid), 32'd0);
    chk("f4_if_hold", bus.if_rdata, 32'h2402_0001);

    // load vs fetch conflict
    tick();
    bus.if_req = 1'b1; bus.if_addr = 32'h10;
    bus.dm_req = 1'b1; bus.dm_addr = 32'h20;
    mid();
    chk("c0_dm_gnt", 32'(bus.dm_gnt), 32'd1);
    chk("c0_if_gnt", 32'(bus.if_gnt), 32'd0);
    chk("c0_ram_addr", 32'(bus.ram_addr), 32'd8);
    chk("c0_ram_wen", 32'(bus.ram_wen), 32'd0);
    tick();
    bus.dm_req = 1'b0;
    mid();
    chk("c1_dm_rvalid", 32'(bus.dm_rvalid), 32'd1);
    chk("c1_dm_rdata", bus.dm_rdata, 32'hDEAD_BEEF);
    chk("c1_if_rvalid", 32'(bus.if_rvalid), 32'd0);
    chk("c1_if_gnt", 32'(bus.if_gnt), 32'd1);
    tick();
    bus.if_req = 1'b0;
    mid();
    chk("c2_if_rvalid", 32'(bus.if_rvalid), 32'd1);
    chk("c2_if_rdata", bus.if_rdata, 32'h2402_0001);
    chk("c2_dm_hold", bus.dm_rdata, 32'hDEAD_BEEF);

    // starvation with STARVE_MAX=3: data wins cycles 0-2, fetch forced in 3
    tick();
    bus.if_req = 1'b1; bus.dm_req = 1'b1;
    for (int c = 0; c < 5; c++) begin
      mid();
      exp_cnt = (c == 4) ? 32'd0 : 32'(c);
      chk("s_dm_gnt", 32'(bus.dm_gnt), (c == 3) ? 32'd0 : 32'd1);
      chk("s_if_gnt", 32'(bus.if_gnt), (c == 3) ? 32'd1 : 32'd0);
      chk("s_starve_cnt", 32'(starve_cnt_dbg), exp_cnt);
      chk("s_if_rvalid", 32'(bus.if_rvalid), (c == 4) ? 32'd1 : 32'd0);
      tick();
    end
    bus.if_req = 1'b0; bus.dm_req = 1'b0;
    mid();
    chk("s5_dm_rvalid", 32'(bus.dm_rvalid), 32'd1);
    chk("s5_if_rvalid", 32'(bus.if_rvalid), 32'd0);

    // store of low half, then reload
    tick();
    bus.dm_req = 1'b1; bus.dm_wen = 4'b0011; bus.dm_addr = 32'h40; bus.dm_wdata = 32'h1234_5678;
    mid();
    chk("w0_dm_gnt", 32'(bus.dm_gnt), 32'd1);
    chk("w0_ram_wen", 32'(bus.ram_wen), 32'h3);
    chk("w0_ram_addr", 32'(bus.ram_addr), 32'd16);
    chk("w0_ram_wdata", bus.ram_wdata, 32'h1234_5678);
    tick();
    bus.dm_req = 1'b0; bus.dm_wen = 4'b0000;
    mid();
    chk("w1_dm_rvalid", 32'(bus.dm_rvalid), 32'd0);
    chk("w1_owner", 32'(owner_dbg), 32'(OWN_NONE));
    tick();
    bus.dm_req = 1'b1;
    mid();
    chk("w2_dm_gnt", 32'(bus.dm_gnt), 32'd1);
    tick();
    bus.dm_req = 1'b0;
    exp_dm = 32'hAAAA_5678;
    mid();
    chk("w3_dm_rvalid", 32'(bus.dm_rvalid), 32'd1);
    chk("w3_dm_rdata", bus.dm_rdata, exp_dm);

    // cancel in the grant cycle
    tick();
    bus.if_req = 1'b1; bus.if_addr = 32'h14; bus.cancel = 1'b1;
    mid();
    chk("k0_if_gnt", 32'(bus.if_gnt), 32'd1);
    tick();
    bus.if_req = 1'b0; bus.cancel = 1'b0;
    mid();
    chk("k1_if_rvalid", 32'(bus.if_rvalid), 32'd0);
    chk("k1_if_rdata", bus.if_rdata, 32'h2402_0001);

    // cancel in the response cycle
    tick();
    bus.if_req = 1'b1;
    mid();
    tick();
    bus.if_req = 1'b0; bus.cancel = 1'b1;
    mid();
    chk("k2_if_rvalid", 32'(bus.if_rvalid), 32'd0);
    chk("k2_if_rdata", bus.if_rdata, 32'h2402_0001);

    // data response ignores cancel
    tick();
    bus.cancel = 1'b0; bus.dm_req = 1'b1; bus.dm_addr = 32'h20;
    mid();
    tick();
    bus.dm_req = 1'b0; bus.cancel = 1'b1;
    mid();
    chk("k3_dm_rvalid", 32'(bus.dm_rvalid), 32'd1);
    chk("k3_dm_rdata", bus.dm_rdata, 32'hDEAD_BEEF);

    // uncancelled fetch of word 5
    tick();
    bus.cancel = 1'b0; bus.if_req = 1'b1;
    mid();
    tick();
    bus.if_req = 1'b0;
    mid();
    chk("k4_if_rvalid", 32'(bus.if_rvalid), 32'd1);
    chk("k4_if_rdata", bus.if_rdata, 32'h1111_2222);

    // asynchronous reset between grant and response
    tick();
    bus.if_req = 1'b1; bus.if_addr = 32'h10;
    mid();
    chk("r0_if_gnt", 32'(bus.if_gnt), 32'd1);
    tick();
    bus.if_req = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("r1_if_rvalid", 32'(bus.if_rvalid), 32'd0);
    chk("r1_if_rdata", bus.if_rdata, 32'h0);
    chk("r1_dm_rvalid", 32'(bus.dm_rvalid), 32'd0);
    chk("r1_dm_rdata", bus.dm_rdata, 32'h0);
    chk("r1_owner", 32'(owner_dbg), 32'(OWN_NONE));
    mid();
    #1 reset = 1'b0;
    tick();
    bus.if_req = 1'b1;
    mid();
    chk("r2_if_gnt", 32'(bus.if_gnt), 32'd1);
    chk("r2_if_rvalid", 32'(bus.if_rvalid), 32'd0);
    tick();
    bus.if_req = 1'b0;
    mid();
    chk("r3_if_rvalid", 32'(bus.if_rvalid), 32'd1);
    chk("r3_if_rdata", bus.if_rdata, 32'h2402_0001);

    // final report
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
